// File: rtl/note_scan_ctrl.sv
// note_scan_ctrl
// Four-digit time-multiplexed seven-segment controller for the FPGA piano.
// Remembers the last four distinct notes played (newest on the rightmost
// digit) and scans the anodes. Each digit slot starts with a blanking
// interval so that the segment pattern of one digit never ghosts onto the next.
module note_scan_ctrl #(
    parameter int DIGIT_TICKS = 100000,  // cycles per digit slot, >= 2
    parameter int BLANK_TICKS = 1000     // blank cycles at slot start, < DIGIT_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] note,
    input  logic       clr,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int              TW        = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0]   BLANK_END = TW'(BLANK_TICKS);
    localparam logic [3:0]      NOTE_NONE = 4'd8;

    // Scan position
    logic [TW-1:0]   tick_cnt_reg;
    logic [TW-1:0]   tick_cnt_next;
    logic [1:0]      dig_reg;
    logic [1:0]      dig_next;
    logic            slot_end;

    // Note capture and history (hist_reg[0] is the newest note)
    logic [3:0]      note_q_reg;
    logic            capture;
    logic [3:0][3:0] hist_reg;
    logic [3:0][3:0] shift_in;

    // Registered display outputs
    logic [3:0]      shown_note;
    logic            blank_phase;
    logic [7:0]      seg_reg;
    logic [7:0]      seg_next;
    logic [3:0]      an_reg;
    logic [3:0]      an_next;

    // Active-low {P,G,F,E,D,C,B,A} glyph for a note code; codes 8..15 are blank.
    function automatic logic [7:0] decode(input logic [3:0] code);
        logic [7:0] glyph;
        case (code)
            4'd0:    glyph = 8'b0100_0110;  // C with DP: octave 5
            4'd1:    glyph = 8'b1000_0011;  // b
            4'd2:    glyph = 8'b1000_1000;  // A
            4'd3:    glyph = 8'b1100_0010;  // G
            4'd4:    glyph = 8'b1000_1110;  // F
            4'd5:    glyph = 8'b1000_0110;  // E
            4'd6:    glyph = 8'b1010_0001;  // d
            4'd7:    glyph = 8'b1100_0110;  // C
            default: glyph = 8'hFF;
        endcase
        return glyph;
    endfunction

    // A new event only when a real note differs from last cycle's note, so a
    // held key fires once and a repeat must pass through "none" first.
    assign capture = (note < NOTE_NONE) && (note != note_q_reg);

    // Shift chain: each slot takes the value of its newer neighbour on capture.
    for (genvar gi = 0; gi < 4; gi++) begin : g_shift
        if (gi == 0) begin : g_head
            assign shift_in[gi] = note;
        end else begin : g_tail
            assign shift_in[gi] = hist_reg[gi-1];
        end
    end

    // Last-cycle note register, updated every cycle even during a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q_reg <= NOTE_NONE;
        end else begin
            note_q_reg <= note;
        end
    end

    // History register: clear has priority over a simultaneous capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= {4{NOTE_NONE}};
        end else if (clr) begin
            hist_reg <= {4{NOTE_NONE}};
        end else if (capture) begin
            hist_reg <= shift_in;
        end
    end

    // Next scan position: tick wraps at slot end and advances the digit.
    always_comb begin
        slot_end      = (tick_cnt_reg == TICK_LAST);
        tick_cnt_next = slot_end ? '0 : tick_cnt_reg + TW'(1);
        dig_next      = slot_end ? dig_reg + 2'd1 : dig_reg;
    end

    // Scan position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
            dig_reg      <= 2'd0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
            dig_reg      <= dig_next;
        end
    end

    // Display pattern for the current scan position; all off while blanking.
    always_comb begin
        shown_note  = hist_reg[dig_reg];
        blank_phase = (tick_cnt_reg < BLANK_END);
        if (blank_phase) begin
            an_next  = 4'hF;
            seg_next = 8'hFF;
        end else begin
            an_next  = ~(4'b0001 << dig_reg);
            seg_next = decode(shown_note);
        end
    end

    // Output register so seg and an always switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= 8'hFF;
            an_reg  <= 4'hF;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;

endmodule

// File: doc/note_scan_ctrl.md
# note_scan_ctrl

- Time-multiplexed four-digit seven-segment controller for the FPGA piano.
- Keeps a history of the last four distinct notes played and shows the newest on the rightmost digit.
- Scans the four anodes in turn, inserting a blanking interval at the start of each digit slot to suppress ghosting.
- Sits between the keyboard note decoder and the board display pins, and replaces the single-digit static display.

## Interface

- DIGIT_TICKS, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- BLANK_TICKS, default 1000: cycles at the start of each slot with all anodes off; must be < DIGIT_TICKS.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- note  in  4  current note code, synchronous to clk:
  - 0 = C5, 1 = B, 2 = A, 3 = G, 4 = F, 5 = E, 6 = D, 7 = C4.
  - 8 = none; codes 9–15 are also treated as none.
- clr  in  1  synchronous single-cycle pulse; empties the history.
- seg  out  8  segment cathodes, active-low, bit order {P,G,F,E,D,C,B,A}.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.

## Operation

- **Note capture**
  - note_q registers note every cycle.
  - A capture event occurs when note ≠ none and note ≠ note_q.
  - On a capture event the history shifts: hist3←hist2, hist2←hist1, hist1←hist0, hist0←note.
  - Holding a key produces one event only. Changing directly from one note to another produces a new event.
  - Repeating the same note requires passing through none in between.
- **Clear**
  - clr sets hist0..3 to 8 (none).
  - If clr and a capture event occur in the same cycle, clr wins and the note is dropped.
  - note_q still updates in that cycle, so the held note is not re-captured afterwards.
- **Scan**
  - tick_cnt is $clog2(DIGIT_TICKS) bits wide and counts 0..DIGIT_TICKS−1, then wraps to 0.
  - On each wrap, digit index dig (2 bits) increments 0→1→2→3→0.
  - In the blank phase (tick_cnt < BLANK_TICKS): an = 4'b1111, seg = 8'hFF.
  - In the show phase: an = ~(1 << dig) and seg = decode(hist[dig]).
- **Decode** ({P,G,F,E,D,C,B,A}, active-low):
  - 0 → 01000110 (C with DP lit, marking octave 5)
  - 1 → 10000011 (b)
  - 2 → 10001000 (A)
  - 3 → 11000010 (G)
  - 4 → 10001110 (F)
  - 5 → 10000110 (E)
  - 6 → 10100001 (d)
  - 7 → 11000110 (C)
  - 8–15 → 11111111 (blank)
- An empty history slot therefore shows a blank digit while its anode is still driven.

## Timing

- **Reset values** (rst_n low, asynchronous):
  - seg = 8'hFF, an = 4'hF
  - tick_cnt = 0, dig = 0
  - note_q = 8, hist0..3 = 8
- After rst_n rises, scanning starts immediately, beginning with the blank phase of digit 0.
- seg and an are registered and change together. They reflect the tick_cnt, dig and hist values of the previous cycle (1-cycle latency).
- History update latency:
  - note changes at edge N; note_q and hist0 update at edge N+1.
  - If digit 0 is in its show phase, seg reflects the new hist0 at edge N+2.
- A history change mid-slot takes effect on the next cycle; there is no wait for a slot boundary.
- The anode transition between digits always passes through the full blank phase, so two anodes are never active in the same cycle.
- Full scan period is 4·DIGIT_TICKS cycles. Each digit is lit for DIGIT_TICKS−BLANK_TICKS cycles per period.
- If rst_n is asserted mid-slot or mid-shift, all state returns to its reset value; no partial shift is retained.

## Test plan

Params: DIGIT_TICKS = 8, BLANK_TICKS = 2.

1. **Reset and idle:** release rst_n, no notes. Required:
   - Outputs are FF/F until cycle 3 after release.
   - From then on, an cycles 1110, 1101, 1011, 0111 with 6 lit cycles and 2 blank cycles (an = 1111) per slot.
   - seg = FF throughout.
2. **Single capture:** note = 3 held for 20 cycles, then 8. Required:
   - hist0 = 3 (one event only).
   - seg = 11000010 whenever an = 1110.
   - Other digits show FF.
3. **History shift:** play 0, 8, 5, 8, 1, 8, 7, 8, then 2. Required:
   - hist0..3 = 2, 7, 1, 5 (oldest note 0 dropped).
   - Digit 3 shows 10000110.
4. **Direct change and repeat:** 4→6 with no none between, then 6 held, then 8, then 6. Required: three events; history = 6, 6, 4.
5. **Clear collision:** clr pulses in the same cycle as the rising edge of note = 2. Required:
   - All hist = 8 and 2 is not captured.
   - Holding 2 afterwards adds nothing.
6. **Async reset mid-slot:** assert rst_n low at tick_cnt = 5 of digit 2 with a non-empty history. Required:
   - an = F and seg = FF within the same cycle, without waiting for a clock edge.
   - hist is all 8 after release.
